// File: rtl/bw_min_max_finder.sv
// Bounding-box and set-pixel-count scanner for the 1-bit black/white image buffer.
// Reads the buffer row-major, one pixel per clock, and holds the last result until the next scan.
module bw_min_max_finder #(
    parameter int unsigned IMG_W   = 320,
    parameter int unsigned IMG_H   = 240,
    parameter int unsigned ADDR_W  = 17,
    parameter int unsigned COORD_W = 9,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               ack,
    output logic               done,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic               rd_data,
    output logic [COORD_W-1:0] x_min,
    output logic [COORD_W-1:0] x_max,
    output logic [COORD_W-1:0] y_min,
    output logic [COORD_W-1:0] y_max,
    output logic               found,
    output logic [ADDR_W-1:0]  pixel_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SCAN   = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_UPDATE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam int unsigned NPIX    = IMG_W * IMG_H;
    localparam int unsigned LAT     = RD_LAT;
    localparam int unsigned DRAIN_W = 2;

    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(NPIX - 1);
    localparam logic [COORD_W-1:0] X_LAST     = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST     = COORD_W'(IMG_H - 1);
    // rd_addr is registered one cycle behind addr_cnt, so draining covers RD_LAT + 1 edges.
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(RD_LAT);

    logic [2:0]         state_q, state_d;
    logic               done_q, done_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]  addr_cnt_q, addr_cnt_d;
    logic [COORD_W-1:0] x_cnt_q, x_cnt_d;
    logic [COORD_W-1:0] y_cnt_q, y_cnt_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;

    logic [COORD_W-1:0] wx_min_q, wx_min_d, wx_max_q, wx_max_d;
    logic [COORD_W-1:0] wy_min_q, wy_min_d, wy_max_q, wy_max_d;
    logic               wfound_q, wfound_d;
    logic [ADDR_W-1:0]  wcount_q, wcount_d;

    logic [COORD_W-1:0] x_min_q, x_min_d, x_max_q, x_max_d;
    logic [COORD_W-1:0] y_min_q, y_min_d, y_max_q, y_max_d;
    logic               found_q, found_d;
    logic [ADDR_W-1:0]  count_q, count_d;

    // Coordinate tag pipe: stage 0 is aligned with rd_addr, stage LAT with rd_data.
    logic [COORD_W-1:0] tag_x_q [LAT+1];
    logic [COORD_W-1:0] tag_x_d [LAT+1];
    logic [COORD_W-1:0] tag_y_q [LAT+1];
    logic [COORD_W-1:0] tag_y_d [LAT+1];
    logic [LAT:0]       tag_v_q, tag_v_d;

    logic               hit_c;
    logic [COORD_W-1:0] hit_x_c, hit_y_c;

    assign hit_c   = tag_v_q[LAT] & rd_data;
    assign hit_x_c = tag_x_q[LAT];
    assign hit_y_c = tag_y_q[LAT];

    // Next-state, accumulation and result logic.
    always_comb begin
        state_d    = state_q;
        done_d     = done_q;
        rd_addr_d  = rd_addr_q;
        addr_cnt_d = addr_cnt_q;
        x_cnt_d    = x_cnt_q;
        y_cnt_d    = y_cnt_q;
        drain_d    = drain_q;
        wx_min_d   = wx_min_q;
        wx_max_d   = wx_max_q;
        wy_min_d   = wy_min_q;
        wy_max_d   = wy_max_q;
        wfound_d   = wfound_q;
        wcount_d   = wcount_q;
        x_min_d    = x_min_q;
        x_max_d    = x_max_q;
        y_min_d    = y_min_q;
        y_max_d    = y_max_q;
        found_d    = found_q;
        count_d    = count_q;

        tag_v_d    = '0;
        tag_x_d[0] = tag_x_q[0];
        tag_y_d[0] = tag_y_q[0];
        for (int unsigned i = 1; i <= LAT; i++) begin
            tag_v_d[i] = tag_v_q[i-1];
            tag_x_d[i] = tag_x_q[i-1];
            tag_y_d[i] = tag_y_q[i-1];
        end

        if (hit_c) begin
            if (hit_x_c < wx_min_q) wx_min_d = hit_x_c;
            if (hit_x_c > wx_max_q) wx_max_d = hit_x_c;
            if (hit_y_c < wy_min_q) wy_min_d = hit_y_c;
            if (hit_y_c > wy_max_q) wy_max_d = hit_y_c;
            wcount_d = wcount_q + ADDR_W'(1);
            wfound_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_SCAN;
                    addr_cnt_d = '0;
                    x_cnt_d    = '0;
                    y_cnt_d    = '0;
                    wx_min_d   = X_LAST;
                    wx_max_d   = '0;
                    wy_min_d   = Y_LAST;
                    wy_max_d   = '0;
                    wfound_d   = 1'b0;
                    wcount_d   = '0;
                end
            end
            S_SCAN: begin
                rd_addr_d  = addr_cnt_q;
                tag_v_d[0] = 1'b1;
                tag_x_d[0] = x_cnt_q;
                tag_y_d[0] = y_cnt_q;
                addr_cnt_d = addr_cnt_q + ADDR_W'(1);
                if (x_cnt_q == X_LAST) begin
                    x_cnt_d = '0;
                    y_cnt_d = y_cnt_q + COORD_W'(1);
                end else begin
                    x_cnt_d = x_cnt_q + COORD_W'(1);
                end
                if (addr_cnt_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_UPDATE;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            S_UPDATE: begin
                if (wfound_q) begin
                    x_min_d = wx_min_q;
                    x_max_d = wx_max_q;
                    y_min_d = wy_min_q;
                    y_max_d = wy_max_q;
                    found_d = 1'b1;
                    count_d = wcount_q;
                end else begin
                    found_d = 1'b0;
                    count_d = '0;
                end
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_DONE: begin
                if (ack) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            done_q     <= 1'b0;
            rd_addr_q  <= '0;
            addr_cnt_q <= '0;
            x_cnt_q    <= '0;
            y_cnt_q    <= '0;
            drain_q    <= '0;
            wx_min_q   <= '0;
            wx_max_q   <= '0;
            wy_min_q   <= '0;
            wy_max_q   <= '0;
            wfound_q   <= 1'b0;
            wcount_q   <= '0;
            x_min_q    <= '0;
            x_max_q    <= '0;
            y_min_q    <= '0;
            y_max_q    <= '0;
            found_q    <= 1'b0;
            count_q    <= '0;
            tag_v_q    <= '0;
            for (int unsigned i = 0; i <= LAT; i++) begin
                tag_x_q[i] <= '0;
                tag_y_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            rd_addr_q  <= rd_addr_d;
            addr_cnt_q <= addr_cnt_d;
            x_cnt_q    <= x_cnt_d;
            y_cnt_q    <= y_cnt_d;
            drain_q    <= drain_d;
            wx_min_q   <= wx_min_d;
            wx_max_q   <= wx_max_d;
            wy_min_q   <= wy_min_d;
            wy_max_q   <= wy_max_d;
            wfound_q   <= wfound_d;
            wcount_q   <= wcount_d;
            x_min_q    <= x_min_d;
            x_max_q    <= x_max_d;
            y_min_q    <= y_min_d;
            y_max_q    <= y_max_d;
            found_q    <= found_d;
            count_q    <= count_d;
            tag_v_q    <= tag_v_d;
            for (int unsigned i = 0; i <= LAT; i++) begin
                tag_x_q[i] <= tag_x_d[i];
                tag_y_q[i] <= tag_y_d[i];
            end
        end
    end

    assign done        = done_q;
    assign rd_addr     = rd_addr_q;
    assign x_min       = x_min_q;
    assign x_max       = x_max_q;
    assign y_min       = y_min_q;
    assign y_max       = y_max_q;
    assign found       = found_q;
    assign pixel_count = count_q;

endmodule

// File: tb/tb_bw_min_max_finder.sv
// Bench for bw_min_max_finder: a 16x12 image scanned by two instances (read latency 1 and 2)
// sharing one image and one handshake; expected results queue per instance, popped on done.
module tb_bw_min_max_finder;

    localparam int unsigned W  = 16;
    localparam int unsigned H  = 12;
    localparam int unsigned AW = 8;
    localparam int unsigned CW = 9;
    localparam int NP = W * H;

    typedef struct {
        logic          found;
        logic [CW-1:0] xmin;
        logic [CW-1:0] xmax;
        logic [CW-1:0] ymin;
        logic [CW-1:0] ymax;
        logic [AW-1:0] cnt;
    } res_t;

    typedef struct {
        int   x0;
        int   x1;
        int   y0;
        int   y1;
        bit   hold;
        res_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic ack = 1'b0;

    logic [1:0]         done_s;
    logic [1:0][AW-1:0] addr_s;
    logic [1:0]         rdata_s;
    logic [1:0][CW-1:0] xmin_s, xmax_s, ymin_s, ymax_s;
    logic [1:0]         found_s;
    logic [1:0][AW-1:0] cnt_s;
    logic               m2_stage;

    bit   img [256];
    res_t sbq0 [$];
    res_t sbq1 [$];
    res_t last;
    vec_t tbl [8];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bw_min_max_finder #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .COORD_W(CW), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .ack(ack), .done(done_s[0]),
        .rd_addr(addr_s[0]), .rd_data(rdata_s[0]),
        .x_min(xmin_s[0]), .x_max(xmax_s[0]), .y_min(ymin_s[0]), .y_max(ymax_s[0]),
        .found(found_s[0]), .pixel_count(cnt_s[0])
    );

    bw_min_max_finder #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .COORD_W(CW), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .ack(ack), .done(done_s[1]),
        .rd_addr(addr_s[1]), .rd_data(rdata_s[1]),
        .x_min(xmin_s[1]), .x_max(xmax_s[1]), .y_min(ymin_s[1]), .y_max(ymax_s[1]),
        .found(found_s[1]), .pixel_count(cnt_s[1])
    );

    // Block-memory models: one and two register stages on the read path.
    always_ff @(posedge clk) begin
        rdata_s[0] <= img[addr_s[0]];
        m2_stage   <= img[addr_s[1]];
        rdata_s[1] <= m2_stage;
    end

    task automatic chk(input string nm, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", nm, d + 1, act, exp, $time);
        end
    endtask

    task automatic check_res(input int d, input res_t e);
        chk("found", d, int'(found_s[d]), int'(e.found));
        chk("x_min", d, int'(xmin_s[d]), int'(e.xmin));
        chk("x_max", d, int'(xmax_s[d]), int'(e.xmax));
        chk("y_min", d, int'(ymin_s[d]), int'(e.ymin));
        chk("y_max", d, int'(ymax_s[d]), int'(e.ymax));
        chk("pixel_count", d, int'(cnt_s[d]), int'(e.cnt));
    endtask

    function automatic res_t mkres(bit f, int a, int b, int c, int dd, int n);
        res_t r;
        r.found = f;
        r.xmin  = CW'(a);
        r.xmax  = CW'(b);
        r.ymin  = CW'(c);
        r.ymax  = CW'(dd);
        r.cnt   = AW'(n);
        return r;
    endfunction

    function automatic vec_t mkvec(int x0, int x1, int y0, int y1, bit hold, res_t e);
        vec_t v;
        v.x0 = x0; v.x1 = x1; v.y0 = y0; v.y1 = y1; v.hold = hold; v.exp = e;
        return v;
    endfunction

    task automatic set_rect(input int x0, input int x1, input int y0, input int y1);
        for (int a = 0; a < 256; a++) img[a] = 1'b0;
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                img[y * W + x] = 1'b1;
    endtask

    // Reference scan of the current image; an empty image keeps the previous box.
    function automatic res_t model(input res_t prev);
        res_t r;
        r = mkres(1'b0, W - 1, 0, H - 1, 0, 0);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (img[y * W + x]) begin
                    r.found = 1'b1;
                    r.cnt   = r.cnt + AW'(1);
                    if (CW'(x) < r.xmin) r.xmin = CW'(x);
                    if (CW'(x) > r.xmax) r.xmax = CW'(x);
                    if (CW'(y) < r.ymin) r.ymin = CW'(y);
                    if (CW'(y) > r.ymax) r.ymax = CW'(y);
                end
            end
        end
        if (!r.found) begin
            r.xmin = prev.xmin; r.xmax = prev.xmax;
            r.ymin = prev.ymin; r.ymax = prev.ymax;
        end
        return r;
    endfunction

    // One full scan: push expectation, pulse (or hold) start, wait for done, compare, acknowledge.
    task automatic run_scan(input res_t e, input bit hold);
        int lat [2];
        res_t got;
        sbq0.push_back(e);
        sbq1.push_back(e);
        lat[0] = -1;
        lat[1] = -1;
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int k = 1; k <= NP + 20; k++) begin
            @(negedge clk);
            if (k == NP / 2) begin
                for (int d = 0; d < 2; d++) begin
                    chk("mid_scan_done", d, int'(done_s[d]), 0);
                    chk("mid_scan_found", d, int'(found_s[d]), int'(last.found));
                    chk("mid_scan_count", d, int'(cnt_s[d]), int'(last.cnt));
                    chk("mid_scan_x_max", d, int'(xmax_s[d]), int'(last.xmax));
                end
            end
            for (int d = 0; d < 2; d++) begin
                if (done_s[d] && lat[d] < 0) begin
                    lat[d] = k;
                    got = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
                    check_res(d, got);
                end
            end
            if (lat[0] >= 0 && lat[1] >= 0) break;
        end
        for (int d = 0; d < 2; d++) begin
            chk("done_latency", d, lat[d], NP + d + 3);
            if (lat[d] < 0) begin
                if (d == 0) void'(sbq0.pop_front());
                else        void'(sbq1.pop_front());
            end
        end
        last = e;
        if (hold) begin
            int low_cycles = 0;
            repeat (30) begin
                @(negedge clk);
                if (!done_s[0] || !done_s[1]) low_cycles++;
            end
            chk("done_held_without_ack", 0, low_cycles, 0);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        start = 1'b0;
        for (int d = 0; d < 2; d++) chk("done_after_ack", d, int'(done_s[d]), 0);
        if (hold) begin
            int busy = 0;
            repeat (NP / 4) begin
                @(negedge clk);
                if (done_s != 2'b00 || addr_s[0] != AW'(NP - 1) || addr_s[1] != AW'(NP - 1)) busy++;
            end
            chk("no_rescan_after_held_start", 0, busy, 0);
        end
    endtask

    initial begin
        tbl[0] = mkvec(1, 0, 0, 0,    1'b0, mkres(1'b0, 0, 0, 0, 0, 0));
        tbl[1] = mkvec(0, 0, 0, 0,    1'b0, mkres(1'b1, 0, 0, 0, 0, 1));
        tbl[2] = mkvec(15, 15, 11, 11, 1'b0, mkres(1'b1, 15, 15, 11, 11, 1));
        tbl[3] = mkvec(5, 9, 3, 7,    1'b1, mkres(1'b1, 5, 9, 3, 7, 25));
        tbl[4] = mkvec(0, 15, 0, 11,  1'b0, mkres(1'b1, 0, 15, 0, 11, 192));
        tbl[5] = mkvec(1, 0, 0, 0,    1'b0, mkres(1'b0, 0, 15, 0, 11, 0));
        tbl[6] = mkvec(3, 3, 0, 11,   1'b0, mkres(1'b1, 3, 3, 0, 11, 12));
        tbl[7] = mkvec(0, 15, 4, 4,   1'b0, mkres(1'b1, 0, 15, 4, 4, 16));

        last = mkres(1'b0, 0, 0, 0, 0, 0);
        set_rect(1, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("reset_done", d, int'(done_s[d]), 0);
            chk("reset_rd_addr", d, int'(addr_s[d]), 0);
            check_res(d, last);
        end

        for (int i = 0; i < 8; i++) begin
            set_rect(tbl[i].x0, tbl[i].x1, tbl[i].y0, tbl[i].y1);
            run_scan(tbl[i].exp, tbl[i].hold);
        end

        // Reset in the middle of a scan aborts it and clears every output.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last = mkres(1'b0, 0, 0, 0, 0, 0);
        for (int d = 0; d < 2; d++) begin
            chk("abort_done", d, int'(done_s[d]), 0);
            chk("abort_rd_addr", d, int'(addr_s[d]), 0);
            check_res(d, last);
        end
        run_scan(mkres(1'b1, 0, 15, 4, 4, 16), 1'b0);

        // Two random images checked against the reference scan.
        for (int r = 0; r < 2; r++) begin
            for (int a = 0; a < 256; a++) img[a] = 1'b0;
            for (int a = 0; a < NP; a++) img[a] = ($urandom_range(0, 9) == 0);
            run_scan(model(last), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
